avalon_bus_arbiter: RTL and testbench

Two-requester arbiter that shares the CPU's single Avalon memory-mapped master port between the instruction-fetch unit and the load/store (data) unit. It sits between the CPU datapath and the external `RAM` / Avalon slave. It registers one transfer at a time onto the bus, holds it stable through `waitrequest`, returns read data and a one-cycle completion pulse to the granted requester, and aborts transfers that stall too long.

---
 rtl/avalon_bus_arbiter_if.sv | 20 ++
 rtl/avalon_bus_arbiter.sv | 142 ++++++++++++++
 tb/tb_avalon_bus_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_bus_arbiter_if.sv
// Avalon-MM master bus bundle between the arbiter and the memory slave.
interface avalon_bus_arbiter_if;
    logic [31:0] address;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        read;
    logic        write;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (
        output address, writedata, byteenable, read, write,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, writedata, byteenable, read, write,
        output waitrequest, readdata
    );
endinterface

// File: rtl/avalon_bus_arbiter.sv
// Shares one Avalon-MM master port between the fetch and load/store units, one transfer at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin on contention; otherwise data has fixed priority.
module avalon_bus_arbiter #(
    parameter int unsigned Timeout = 1024
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 i_req_i,
    input  logic [31:0]          i_address_i,
    output logic                 i_done_o,
    output logic [31:0]          i_readdata_o,
    input  logic                 d_req_i,
    input  logic                 d_write_i,
    input  logic [31:0]          d_address_i,
    input  logic [31:0]          d_writedata_i,
    input  logic [3:0]           d_byteenable_i,
    output logic                 d_done_o,
    output logic [31:0]          d_readdata_o,
    output logic                 bus_err_o,
    avalon_bus_arbiter_if.master bus
);

    localparam int unsigned StallW = (Timeout > 1) ? $clog2(Timeout) : 1;

    typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

    state_e              state_q;
    logic [31:0]         address_q;
    logic [31:0]         writedata_q;
    logic [3:0]          byteenable_q;
    logic                read_q;
    logic                write_q;
    logic                i_done_q;
    logic                d_done_q;
    logic [31:0]         i_rdata_q;
    logic [31:0]         d_rdata_q;
    logic                bus_err_q;
    logic [StallW-1:0]   stall_q;
`ifdef ARB_ROUND_ROBIN_EN
    logic                prefer_d_q;
`endif

    logic i_elig, d_elig, grant_i, grant_d, timed_out;

    always_comb begin
        // A requester is masked during its own done cycle, giving the one-cycle bus gap.
        i_elig = i_req_i && !i_done_q;
        d_elig = d_req_i && !d_done_q;
`ifdef ARB_ROUND_ROBIN_EN
        grant_d = d_elig && (!i_elig || prefer_d_q);
`else
        grant_d = d_elig;
`endif
        grant_i = i_elig && !grant_d;
        // Current cycle is the Timeout-th consecutive stall cycle.
        timed_out = (Timeout != 0) && (stall_q == StallW'(Timeout - 1));
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            address_q    <= '0;
            writedata_q  <= '0;
            byteenable_q <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            i_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            bus_err_q    <= 1'b0;
            stall_q      <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            prefer_d_q   <= 1'b1;
`endif
        end else begin
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            bus_err_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (grant_d) begin
                        address_q    <= d_address_i;
                        writedata_q  <= d_writedata_i;
                        byteenable_q <= d_byteenable_i;
                        read_q       <= !d_write_i;
                        write_q      <= d_write_i;
                        stall_q      <= '0;
                        state_q      <= StBusyD;
`ifdef ARB_ROUND_ROBIN_EN
                        prefer_d_q   <= 1'b0;
`endif
                    end else if (grant_i) begin
                        address_q    <= i_address_i;
                        writedata_q  <= '0;
                        byteenable_q <= 4'b1111;
                        read_q       <= 1'b1;
                        write_q      <= 1'b0;
                        stall_q      <= '0;
                        state_q      <= StBusyI;
`ifdef ARB_ROUND_ROBIN_EN
                        prefer_d_q   <= 1'b1;
`endif
                    end
                end
                StBusyI, StBusyD: begin
                    if (!bus.waitrequest || timed_out) begin
                        read_q    <= 1'b0;
                        write_q   <= 1'b0;
                        state_q   <= StIdle;
                        i_done_q  <= (state_q == StBusyI);
                        d_done_q  <= (state_q == StBusyD);
                        // Still stalled here means this completion is a timeout abort.
                        bus_err_q <= bus.waitrequest;
                        if (!bus.waitrequest && read_q) begin
                            if (state_q == StBusyD) begin
                                d_rdata_q <= bus.readdata;
                            end else begin
                                i_rdata_q <= bus.readdata;
                            end
                        end
                    end else begin
                        stall_q <= stall_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.address    = address_q;
    assign bus.writedata  = writedata_q;
    assign bus.byteenable = byteenable_q;
    assign bus.read       = read_q;
    assign bus.write      = write_q;
    assign i_done_o       = i_done_q;
    assign d_done_o       = d_done_q;
    assign i_readdata_o   = i_rdata_q;
    assign d_readdata_o   = d_rdata_q;
    assign bus_err_o      = bus_err_q;

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Self-checking bench for avalon_bus_arbiter: vector table, scoreboard queue and an inline slave.
module tb_avalon_bus_arbiter;

    localparam int TimeoutCycles = 8;

    typedef struct {
        logic        is_d;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } cmd_t;

    typedef struct {
        cmd_t        cmd;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_strobe;
    } sb_t;

    typedef struct {
        cmd_t        cmd;
        logic [31:0] rdata;
        int          waits;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, i_done;
    logic [31:0] i_address, i_readdata;
    logic        d_req, d_write, d_done;
    logic [31:0] d_address, d_writedata, d_readdata;
    logic [3:0]  d_byteenable;
    logic        bus_err;

    avalon_bus_arbiter_if bus ();

    avalon_bus_arbiter #(.Timeout(TimeoutCycles)) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .i_req_i        (i_req),
        .i_address_i    (i_address),
        .i_done_o       (i_done),
        .i_readdata_o   (i_readdata),
        .d_req_i        (d_req),
        .d_write_i      (d_write),
        .d_address_i    (d_address),
        .d_writedata_i  (d_writedata),
        .d_byteenable_i (d_byteenable),
        .d_done_o       (d_done),
        .d_readdata_o   (d_readdata),
        .bus_err_o      (bus_err),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          stall = 0;
    int          scyc = 0;
    int          slave_waits = 0;
    logic        fixed_en = 1'b0;
    logic [31:0] slave_rd = '0;
    logic        rose = 1'b0;
    logic [31:0] exp_i_rd = '0;
    logic [31:0] exp_d_rd = '0;
    cmd_t        iq[$];
    cmd_t        dq[$];
    sb_t         sb[$];

    function automatic logic [31:0] model(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        logic [31:0] pa, pw;
        logic [3:0]  pb;
        logic        p_rd, p_wr, p_wait, p_rst, p_id, p_dd;
        pa = bus.address; pw = bus.writedata; pb = bus.byteenable;
        p_rd = bus.read; p_wr = bus.write; p_wait = bus.waitrequest; p_rst = reset;
        p_id = i_done; p_dd = d_done;
        @(posedge clk);
        #1;
        rose = (bus.read || bus.write) && !(p_rd || p_wr);
        check("read_write_exclusive", 32'(bus.read && bus.write), 32'd0);
        if ((p_rd || p_wr) && p_wait && !p_rst) begin
            check("hold_address", bus.address, pa);
            check("hold_writedata", bus.writedata, pw);
            check("hold_byteenable", 32'(bus.byteenable), 32'(pb));
            if (bus.read || bus.write) check("hold_strobes", 32'({bus.read, bus.write}), 32'({p_rd, p_wr}));
        end
        if (p_id) check("i_done_single_cycle", 32'(i_done), 32'd0);
        if (p_dd) check("d_done_single_cycle", 32'(d_done), 32'd0);
        if (!i_done && !d_done) check("bus_err_without_done", 32'(bus_err), 32'd0);
        if (bus.read || bus.write) begin
            if (stall < slave_waits) begin
                bus.waitrequest = 1'b1;
                bus.readdata    = 32'hDEAD_BEEF;
                stall++;
            end else begin
                bus.waitrequest = 1'b0;
                bus.readdata    = fixed_en ? slave_rd : model(bus.address);
            end
        end else begin
            bus.waitrequest = 1'b0;
            bus.readdata    = 32'hDEAD_BEEF;
            stall = 0;
        end
    endtask

    task automatic drive_reqs();
        i_req = (iq.size() != 0);
        if (iq.size() != 0) i_address = iq[0].addr;
        d_req = (dq.size() != 0);
        if (dq.size() != 0) begin
            d_write      = dq[0].wr;
            d_address    = dq[0].addr;
            d_writedata  = dq[0].wdata;
            d_byteenable = dq[0].be;
        end
    endtask

    function automatic int strobe_len(input int waits);
        return (waits >= TimeoutCycles) ? TimeoutCycles : waits + 1;
    endfunction

    task automatic push_txn(input cmd_t c, input int waits);
        sb_t e;
        if (!c.wr && waits < TimeoutCycles) begin
            if (c.is_d) exp_d_rd = model(c.addr);
            else exp_i_rd = model(c.addr);
        end
        e.cmd        = c;
        e.exp_rd     = c.is_d ? exp_d_rd : exp_i_rd;
        e.exp_err    = (waits >= TimeoutCycles);
        e.exp_strobe = strobe_len(waits);
        sb.push_back(e);
        if (c.is_d) dq.push_back(c);
        else iq.push_back(c);
    endtask

    task automatic run(input int budget, output int n);
        sb_t  e;
        cmd_t c;
        n = 0;
        drive_reqs();
        while ((iq.size() != 0 || dq.size() != 0) && n < budget) begin
            tick();
            n++;
            if (rose) begin
                scyc = 0;
                if (sb.size() != 0) begin
                    c = sb[0].cmd;
                    check("bus_address", bus.address, c.addr);
                    check("bus_read", 32'(bus.read), c.is_d ? 32'(!c.wr) : 32'd1);
                    check("bus_write", 32'(bus.write), c.is_d ? 32'(c.wr) : 32'd0);
                    check("bus_byteenable", 32'(bus.byteenable), c.is_d ? 32'(c.be) : 32'hF);
                    check("bus_writedata", bus.writedata, c.is_d ? c.wdata : 32'd0);
                end
            end
            if (bus.read || bus.write) scyc++;
            if (i_done || d_done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'({i_done, d_done}), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("done_requester", 32'(d_done), 32'(e.cmd.is_d));
                    check("done_readdata", e.cmd.is_d ? d_readdata : i_readdata, e.exp_rd);
                    check("done_bus_err", 32'(bus_err), 32'(e.exp_err));
                    check("strobe_cycles", 32'(scyc), 32'(e.exp_strobe));
                end
                if (d_done && dq.size() != 0) void'(dq.pop_front());
                if (i_done && iq.size() != 0) void'(iq.pop_front());
            end
            drive_reqs();
        end
        if (iq.size() != 0 || dq.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL run_budget: %0d transfers pending after %0d cycles, expected 0",
                     iq.size() + dq.size(), n);
            iq.delete();
            dq.delete();
            sb.delete();
            drive_reqs();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_address"}, bus.address, 32'd0);
        check({tag, "_writedata"}, bus.writedata, 32'd0);
        check({tag, "_byteenable"}, 32'(bus.byteenable), 32'd0);
        check({tag, "_strobes"}, 32'({bus.read, bus.write}), 32'd0);
        check({tag, "_dones"}, 32'({i_done, d_done}), 32'd0);
        check({tag, "_i_readdata"}, i_readdata, 32'd0);
        check({tag, "_d_readdata"}, d_readdata, 32'd0);
        check({tag, "_bus_err"}, 32'(bus_err), 32'd0);
    endtask

    initial begin
        vec_t vt[7];
        int   n;
        cmd_t c;
        sb_t  e;

        vt[0] = '{'{1'b0, 1'b0, 32'h4,   32'h0,        4'hF}, 32'h2404FEDC, 0,   32'h2404FEDC, 1'b0, 2};
        vt[1] = '{'{1'b1, 1'b1, 32'h100, 32'hEA410A9D, 4'h3}, 32'h0,        3,   32'h0,        1'b0, 5};
        vt[2] = '{'{1'b1, 1'b0, 32'h200, 32'h0,        4'hF}, 32'h13579BDF, 1,   32'h13579BDF, 1'b0, 3};
        vt[3] = '{'{1'b1, 1'b0, 32'h204, 32'h0,        4'h6}, 32'hCAFE0001, 100, 32'h13579BDF, 1'b1, 9};
        vt[4] = '{'{1'b0, 1'b0, 32'h8,   32'h0,        4'hF}, 32'h0BADF00D, 2,   32'h0BADF00D, 1'b0, 4};
        vt[5] = '{'{1'b1, 1'b1, 32'h208, 32'h0F0F1234, 4'hF}, 32'h0,        7,   32'h13579BDF, 1'b0, 9};
        vt[6] = '{'{1'b1, 1'b0, 32'h300, 32'h0,        4'h1}, 32'h80000001, 0,   32'h80000001, 1'b0, 2};

        reset = 1'b1;
        i_req = 1'b0; i_address = '0;
        d_req = 1'b0; d_write = 1'b0; d_address = '0; d_writedata = '0; d_byteenable = '0;
        bus.waitrequest = 1'b0;
        bus.readdata    = '0;
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;

        fixed_en = 1'b1;
        for (int k = 0; k < 7; k++) begin
            e.cmd        = vt[k].cmd;
            e.exp_rd     = vt[k].exp_rd;
            e.exp_err    = vt[k].exp_err;
            e.exp_strobe = strobe_len(vt[k].waits);
            sb.push_back(e);
            if (vt[k].cmd.is_d) dq.push_back(vt[k].cmd);
            else iq.push_back(vt[k].cmd);
            slave_waits = vt[k].waits;
            slave_rd    = vt[k].rdata;
            run(40, n);
            check($sformatf("latency_vec%0d", k), 32'(n), 32'(vt[k].exp_lat));
            tick();
        end
        check("i_readdata_held", i_readdata, 32'h0BADF00D);
        fixed_en = 1'b0;

        // Reset during the second stall cycle of a fetch, then re-request.
        slave_waits = 5;
        i_address   = 32'h20;
        i_req       = 1'b1;
        tick();
        tick();
        check("pre_reset_strobe", 32'(bus.read), 32'd1);
        reset = 1'b1;
        tick();
        check_all_zero("midreset");
        reset    = 1'b0;
        exp_i_rd = '0;
        exp_d_rd = '0;
        slave_waits = 0;
        c = '{1'b0, 1'b0, 32'h20, 32'h0, 4'hF};
        push_txn(c, 0);
        run(20, n);
        check("latency_after_reset", 32'(n), 32'd2);
        tick();

        // Contention: the done-cycle mask alternates service D, I, D, I.
        slave_waits = 1;
        c = '{1'b1, 1'b0, 32'h400, 32'h0, 4'hF}; push_txn(c, 1);
        c = '{1'b0, 1'b0, 32'h10,  32'h0, 4'hF}; push_txn(c, 1);
        c = '{1'b1, 1'b1, 32'h404, 32'h55AA1234, 4'hC}; push_txn(c, 1);
        c = '{1'b0, 1'b0, 32'h14,  32'h0, 4'hF}; push_txn(c, 1);
        run(60, n);
        tick();

        // Data served alone, then a simultaneous request from both.
        slave_waits = 0;
        c = '{1'b1, 1'b0, 32'h500, 32'h0, 4'hF}; push_txn(c, 0);
        run(20, n);
        tick();
`ifdef ARB_ROUND_ROBIN_EN
        c = '{1'b0, 1'b0, 32'h18,  32'h0, 4'hF}; push_txn(c, 0);
        c = '{1'b1, 1'b0, 32'h504, 32'h0, 4'hF}; push_txn(c, 0);
`else
        c = '{1'b1, 1'b0, 32'h504, 32'h0, 4'hF}; push_txn(c, 0);
        c = '{1'b0, 1'b0, 32'h18,  32'h0, 4'hF}; push_txn(c, 0);
`endif
        run(20, n);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
